// File: rtl/tl_rx_error_report_ctrl.sv
// tl_rx_error_report_ctrl: classifies TLP header-check errors, drops bad TLPs and reports the highest-priority error.
// Optional first-error header log enabled by defining TL_RX_ERR_LOG_EN.
module tl_rx_error_report_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        chk_valid,
  output logic        chk_ready,
  input  logic        EP,
  input  logic        poisoned_en,
  input  logic        ecrc_err,
  input  logic        malformed_err,
  input  logic        ur_err,
  input  logic [15:0] hdr_id,
  output logic        err_valid,
  input  logic        err_ready,
  output logic [1:0]  err_code,
  output logic [15:0] err_id,
  output logic        tlp_drop,
  output logic [7:0]  poison_cnt
`ifdef TL_RX_ERR_LOG_EN
  ,
  input  logic        log_clr,
  output logic        log_valid,
  output logic [15:0] log_id
`endif
);
  typedef enum logic [1:0] {IDLE, EVAL, REPORT} state_t;
  state_t state;
  logic lat_ep, lat_pen, lat_ecrc, lat_mal, lat_ur;
  logic [15:0] lat_id;
  logic in_err, poison, any_err;
  logic [1:0] code;
  assign in_err  = malformed_err | ecrc_err | ur_err | (poisoned_en & EP);
  assign poison  = lat_ep & lat_pen;
  assign any_err = lat_mal | lat_ecrc | lat_ur | poison;
  assign code    = lat_mal ? 2'd3 : lat_ecrc ? 2'd2 : lat_ur ? 2'd1 : 2'd0;
  // tlp_drop is registered at acceptance so it is visible during the EVAL cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      chk_ready  <= 1'b1;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
      err_id     <= 16'd0;
      tlp_drop   <= 1'b0;
      poison_cnt <= 8'd0;
      lat_ep     <= 1'b0;
      lat_pen    <= 1'b0;
      lat_ecrc   <= 1'b0;
      lat_mal    <= 1'b0;
      lat_ur     <= 1'b0;
      lat_id     <= 16'd0;
    end else begin
      case (state)
        IDLE: if (chk_valid) begin
          state     <= EVAL;
          chk_ready <= 1'b0;
          tlp_drop  <= in_err;
          lat_ep    <= EP;
          lat_pen   <= poisoned_en;
          lat_ecrc  <= ecrc_err;
          lat_mal   <= malformed_err;
          lat_ur    <= ur_err;
          lat_id    <= hdr_id;
        end
        EVAL: begin
          tlp_drop <= 1'b0;
          if (poison && poison_cnt != 8'hff) poison_cnt <= poison_cnt + 8'd1;
          if (any_err) begin
            state     <= REPORT;
            err_valid <= 1'b1;
            err_code  <= code;
            err_id    <= lat_id;
          end else begin
            state     <= IDLE;
            chk_ready <= 1'b1;
          end
        end
        REPORT: if (err_ready) begin
          state     <= IDLE;
          chk_ready <= 1'b1;
          err_valid <= 1'b0;
          err_code  <= 2'd0;
          err_id    <= 16'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TL_RX_ERR_LOG_EN
  // sticky log of the first error; clear takes precedence over capture
  always_ff @(posedge clk) begin
    if (!rst_n || log_clr) begin
      log_valid <= 1'b0;
      log_id    <= 16'd0;
    end else if (state == EVAL && any_err && !log_valid) begin
      log_valid <= 1'b1;
      log_id    <= lat_id;
    end
  end
`endif
endmodule

// File: tb/tb_tl_rx_error_report_ctrl.sv
// tb_tl_rx_error_report_ctrl: scoreboard bench for tl_rx_error_report_ctrl (log checks when TL_RX_ERR_LOG_EN is defined).
module tb_tl_rx_error_report_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, chk_valid = 1'b0, chk_ready;
  logic EP = 1'b0, poisoned_en = 1'b0, ecrc_err = 1'b0, malformed_err = 1'b0, ur_err = 1'b0;
  logic [15:0] hdr_id = 16'd0;
  logic err_valid, err_ready = 1'b1, tlp_drop;
  logic [1:0] err_code;
  logic [15:0] err_id;
  logic [7:0] poison_cnt;
`ifdef TL_RX_ERR_LOG_EN
  logic log_clr = 1'b0, log_valid;
  logic [15:0] log_id;
`endif
  int errors = 0, checks = 0, exp_cnt = 0;
  logic [17:0] sb[$];

  tl_rx_error_report_ctrl dut (
    .clk(clk), .rst_n(rst_n), .chk_valid(chk_valid), .chk_ready(chk_ready),
    .EP(EP), .poisoned_en(poisoned_en), .ecrc_err(ecrc_err), .malformed_err(malformed_err),
    .ur_err(ur_err), .hdr_id(hdr_id), .err_valid(err_valid), .err_ready(err_ready),
    .err_code(err_code), .err_id(err_id), .tlp_drop(tlp_drop), .poison_cnt(poison_cnt)
`ifdef TL_RX_ERR_LOG_EN
    , .log_clr(log_clr), .log_valid(log_valid), .log_id(log_id)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // records are popped on the handshake; idle outputs must read zero
  always @(negedge clk) if (rst_n === 1'b1) begin
    if (err_valid === 1'b1 && err_ready === 1'b1) begin
      if (sb.size() == 0) check("sb_unexpected", 1, 0);
      else begin
        logic [17:0] e;
        e = sb.pop_front();
        check("rec_code", 32'(err_code), 32'(e[17:16]));
        check("rec_id", 32'(err_id), 32'(e[15:0]));
      end
    end else if (err_valid === 1'b0) begin
      check("idle_code", 32'(err_code), 0);
      check("idle_id", 32'(err_id), 0);
    end
  end

  task automatic strobe(input logic ep, pen, ecrc, mal, ur, input logic [15:0] id, output logic e);
    chk_valid = 1'b1; EP = ep; poisoned_en = pen; ecrc_err = ecrc; malformed_err = mal; ur_err = ur; hdr_id = id;
    @(posedge clk); #1;
    chk_valid = 1'b0;
    e = mal | ecrc | ur | (ep & pen);
    if ((ep & pen) && exp_cnt != 255) exp_cnt++;
    if (e) sb.push_back({mal ? 2'd3 : ecrc ? 2'd2 : ur ? 2'd1 : 2'd0, id});
    check("drop", 32'(tlp_drop), 32'(e));
    check("eval_ready", 32'(chk_ready), 0);
    check("eval_valid", 32'(err_valid), 0);
  endtask

  task automatic tlp(input logic ep, pen, ecrc, mal, ur, input logic [15:0] id);
    logic e;
    strobe(ep, pen, ecrc, mal, ur, id, e);
    @(posedge clk); #1;
    check("cnt", 32'(poison_cnt), 32'(exp_cnt));
    check("drop_off", 32'(tlp_drop), 0);
    if (e) begin
      check("rpt_valid", 32'(err_valid), 1);
      check("rpt_ready", 32'(chk_ready), 0);
      @(posedge clk); #1;
    end
    check("idle_ready", 32'(chk_ready), 1);
    check("idle_valid", 32'(err_valid), 0);
  endtask

  initial begin
    logic e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(chk_ready), 1);
    check("rst_valid", 32'(err_valid), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_id", 32'(err_id), 0);
    check("rst_drop", 32'(tlp_drop), 0);
    check("rst_cnt", 32'(poison_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tlp(0, 0, 0, 0, 0, 16'h0bad);
    tlp(1, 1, 0, 0, 0, 16'h1234);
    tlp(1, 1, 1, 1, 0, 16'ha5a5);
    tlp(1, 0, 0, 0, 0, 16'h5a5a);
    tlp(0, 0, 0, 0, 1, 16'h00c3);
    tlp(0, 0, 1, 0, 1, 16'h3c00);
    tlp(1, 1, 0, 0, 1, 16'h7e57);
    // backpressure with ignored strobes
    err_ready = 1'b0;
    strobe(0, 0, 1, 0, 0, 16'hbeef, e);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(err_valid), 1);
      check("bp_code", 32'(err_code), 2);
      check("bp_id", 32'(err_id), 32'hbeef);
      check("bp_ready", 32'(chk_ready), 0);
      chk_valid = 1'b1; EP = 1'b1; poisoned_en = 1'b1; malformed_err = 1'b1; hdr_id = 16'hffff;
      @(posedge clk); #1;
    end
    chk_valid = 1'b0;
    malformed_err = 1'b0;
    err_ready = 1'b1;
    check("bp_cnt", 32'(poison_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    check("bp_release", 32'(chk_ready), 1);
    check("bp_done", 32'(err_valid), 0);
    for (int i = 0; i < 260; i++) tlp(1, 1, 0, 0, 0, 16'(i));
    check("sat_cnt", 32'(poison_cnt), 255);
    // reset while a record is pending in REPORT
    err_ready = 1'b0;
    strobe(1, 1, 0, 0, 0, 16'h5555, e);
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(err_valid), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstr_valid", 32'(err_valid), 0);
    check("rstr_cnt", 32'(poison_cnt), 0);
    check("rstr_ready", 32'(chk_ready), 1);
    check("rstr_code", 32'(err_code), 0);
    sb.delete();
    exp_cnt = 0;
    rst_n = 1'b1;
    err_ready = 1'b1;
    @(posedge clk); #1;
    // reset during EVAL
    strobe(0, 0, 0, 1, 0, 16'h7777, e);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rste_drop", 32'(tlp_drop), 0);
    check("rste_valid", 32'(err_valid), 0);
    check("rste_ready", 32'(chk_ready), 1);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rste_after", 32'(err_valid), 0);
`ifdef TL_RX_ERR_LOG_EN
    check("log_rst", 32'(log_valid), 0);
    tlp(0, 0, 0, 1, 0, 16'h0001);
    tlp(0, 0, 0, 0, 1, 16'h0002);
    check("log_first_v", 32'(log_valid), 1);
    check("log_first_id", 32'(log_id), 1);
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr = 1'b0;
    check("log_clr_v", 32'(log_valid), 0);
    check("log_clr_id", 32'(log_id), 0);
    tlp(0, 0, 1, 0, 0, 16'h0003);
    check("log_new_v", 32'(log_valid), 1);
    check("log_new_id", 32'(log_id), 3);
`endif
    tlp(0, 0, 0, 0, 0, 16'h0000);
    check("sb_left", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
